// File: rtl/uart_pkg.sv
// Shared types and baud-rate helpers for the buffered UART transmitter.
// Pure definitions; no latency or backpressure of its own.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    localparam int unsigned BAUD_TABLE [8] = '{
        9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
    };

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO; dout presents the head word combinationally.
// Latency: a write is visible on dout/level the cycle after the write edge.
// Backpressure: writes while full and reads while empty are ignored.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             din,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    // Pointers carry one wrap bit, so their difference is the exact occupancy.
    assign level = wr_ptr - rd_ptr;
    assign full  = level[AW];
    assign empty = (level == '0);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Buffered UART transmitter, 5..9 data bits, 1/2 stop bits, optional parity (UART_TX_PARITY_EN).
// Latency: word written on edge N starts its start bit on edge N+1 when idle; frames run back-to-back.
// Backpressure: full flags a full FIFO; a write while full is dropped and pulses overflow.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic [2:0]                    baud_set,
    input  logic                          stop2,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    output logic                          Rs232_Tx,
    output logic                          Tx_Done,
    output logic                          uart_state
);
    localparam int unsigned DIV_MAX = baud_div(CLK_FREQ, BAUD_TABLE[0]);
    localparam int          DIV_W   = $clog2(DIV_MAX);
    localparam int          BIT_W   = $clog2(DATA_W);

    for (genvar i = 0; i < 8; i++) begin : g_div_chk
        if (baud_div(CLK_FREQ, BAUD_TABLE[i]) < 2) begin : g_too_fast
            $error("uart_frame_tx: baud divisor below 2 for baud_set %0d", i);
        end
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_w
        $error("uart_frame_tx: DATA_W must be in 5..9");
    end

    localparam logic [DIV_W-1:0] TC_TABLE [8] = '{
        DIV_W'(baud_div(CLK_FREQ, BAUD_TABLE[0]) - 1),
        DIV_W'(baud_div(CLK_FREQ, BAUD_TABLE[1]) - 1),
        DIV_W'(baud_div(CLK_FREQ, BAUD_TABLE[2]) - 1),
        DIV_W'(baud_div(CLK_FREQ, BAUD_TABLE[3]) - 1),
        DIV_W'(baud_div(CLK_FREQ, BAUD_TABLE[4]) - 1),
        DIV_W'(baud_div(CLK_FREQ, BAUD_TABLE[5]) - 1),
        DIV_W'(baud_div(CLK_FREQ, BAUD_TABLE[6]) - 1),
        DIV_W'(baud_div(CLK_FREQ, BAUD_TABLE[7]) - 1)
    };

    tx_state_t         state, state_nxt;
    logic [DIV_W-1:0]  baud_cnt;
    logic [DIV_W-1:0]  div_tc_q;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic              stop_cnt, stop_nxt;
    logic [DATA_W-1:0] shift_q;
    logic              stop2_q;
    logic              line_nxt, done_nxt, pop, tick;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .wr_en (wr_en),
        .din   (data_in),
        .rd_en (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign overflow = wr_en & full;
    assign tick     = (baud_cnt == div_tc_q);

`ifdef UART_TX_PARITY_EN
    logic parity_en_q, parity_q;
    always_ff @(posedge Clk) begin
        if (pop) begin
            parity_en_q <= parity_en;
            parity_q    <= (^fifo_dout) ^ parity_odd;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    // Line value is registered: each transition computes the level the line takes next.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        stop_nxt  = stop_cnt;
        line_nxt  = Rs232_Tx;
        done_nxt  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                line_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                    line_nxt  = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                    line_nxt  = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        if (parity_en_q) begin
                            state_nxt = PARITY;
                            line_nxt  = parity_q;
                        end else
`endif
                        begin
                            state_nxt = STOP;
                            stop_nxt  = 1'b0;
                            line_nxt  = 1'b1;
                        end
                    end else begin
                        bit_nxt  = bit_cnt + 1'b1;
                        line_nxt = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                    stop_nxt  = 1'b0;
                    line_nxt  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop2_q && !stop_cnt) begin
                        stop_nxt = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                        line_nxt = 1'b1;
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            state_nxt = START;
                            line_nxt  = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                line_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            Rs232_Tx   <= 1'b1;
            Tx_Done    <= 1'b0;
            uart_state <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_nxt;
            stop_cnt   <= stop_nxt;
            Rs232_Tx   <= line_nxt;
            Tx_Done    <= done_nxt;
            uart_state <= (state_nxt != IDLE);
            baud_cnt   <= (state == IDLE || tick) ? '0 : baud_cnt + 1'b1;
        end
    end

    // Frame settings are captured at pop so input changes only affect later frames.
    always_ff @(posedge Clk) begin
        if (pop) begin
            shift_q  <= fifo_dout;
            div_tc_q <= TC_TABLE[baud_set];
            stop2_q  <= stop2;
        end else if (state == DATA && tick) begin
            shift_q  <= shift_q >> 1;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: 10 clocks per bit at baud_set=5, 20 at baud_set=4.
// 2_304_000 Hz keeps every table divisor at 2 or more while preserving the 10/20-clock bit ratios.
module tb_uart_frame_tx;
    localparam int unsigned CLK_FREQ = 2_304_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       wr_en = 1'b0;
    logic       full, overflow;
    logic [4:0] fifo_level;
    logic [2:0] baud_set = 3'd5;
    logic       stop2 = 1'b0, parity_en = 1'b0, parity_odd = 1'b0;
    logic       tx, done, busy;

    logic [4:0] d5 = '0;
    logic       wr5 = 1'b0, stop2_5 = 1'b0;
    logic       full5_unused, ovf5_unused, busy5_unused;
    logic [4:0] lvl5_unused;
    logic       tx5, done5;

    logic line_tr [0:511];
    logic done_tr [0:511];
    logic st_tr   [0:511];
    logic line5_tr [0:127];
    logic done5_tr [0:127];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .DATA_W(8), .FIFO_DEPTH(16)) dut (
        .Clk(clk), .Rst(rst), .data_in(data_in), .wr_en(wr_en), .full(full),
        .overflow(overflow), .fifo_level(fifo_level), .baud_set(baud_set),
        .stop2(stop2), .parity_en(parity_en), .parity_odd(parity_odd),
        .Rs232_Tx(tx), .Tx_Done(done), .uart_state(busy)
    );

    uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .DATA_W(5), .FIFO_DEPTH(16)) dut5 (
        .Clk(clk), .Rst(rst), .data_in(d5), .wr_en(wr5), .full(full5_unused),
        .overflow(ovf5_unused), .fifo_level(lvl5_unused), .baud_set(baud_set),
        .stop2(stop2_5), .parity_en(1'b0), .parity_odd(1'b0),
        .Rs232_Tx(tx5), .Tx_Done(done5), .uart_state(busy5_unused)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample both DUTs at index i, then advance one clock.
    task automatic record(input int start, input int n);
        for (int i = start; i < start + n; i++) begin
            line_tr[i] = tx;
            done_tr[i] = done;
            st_tr[i]   = busy;
            if (i < 128) begin
                line5_tr[i] = tx5;
                done5_tr[i] = done5;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want 0", busy); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_checks++; if (tx5 !== 1'b1) begin n_fail++; $display("FAIL reset_tx5: got %b want 1", tx5); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_8n1();
        logic [9:0] f;
        f = {1'b1, 8'h55, 1'b0};
        data_in = 8'h55; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL 8n1_level_after_write: got %0d want 1", fifo_level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_before_pop: got %b want 0", busy); end
        tick();
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL 8n1_start_tx: got %b want 0", tx); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL 8n1_start_busy: got %b want 1", busy); end
        n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL 8n1_level_after_pop: got %0d want 0", fifo_level); end
        record(0, 102);
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (line_tr[i] !== f[i/10]) begin n_fail++; $display("FAIL 8n1_line[%0d]: got %b want %b", i, line_tr[i], f[i/10]); end
        end
        n_checks++; if (done_tr[99] !== 1'b0) begin n_fail++; $display("FAIL 8n1_done_early: got %b want 0", done_tr[99]); end
        n_checks++; if (done_tr[100] !== 1'b1) begin n_fail++; $display("FAIL 8n1_done_at_100: got %b want 1", done_tr[100]); end
        n_checks++; if (done_tr[101] !== 1'b0) begin n_fail++; $display("FAIL 8n1_done_width: got %b want 0", done_tr[101]); end
        n_checks++; if (st_tr[99] !== 1'b1) begin n_fail++; $display("FAIL 8n1_busy_at_99: got %b want 1", st_tr[99]); end
        n_checks++; if (st_tr[100] !== 1'b0) begin n_fail++; $display("FAIL 8n1_busy_falls: got %b want 0", st_tr[100]); end
        n_checks++; if (line_tr[100] !== 1'b1) begin n_fail++; $display("FAIL 8n1_idle_line: got %b want 1", line_tr[100]); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0]  w    [3];
        logic        odd  [3];
        logic        pexp [3];
        logic [10:0] f;
        w = '{8'h55, 8'h07, 8'h07};
        odd = '{1'b0, 1'b1, 1'b0};
        pexp = '{1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 3; c++) begin
            parity_en = 1'b1; parity_odd = odd[c];
            data_in = w[c]; wr_en = 1'b1;
            tick();
            wr_en = 1'b0;
            tick();
            record(0, 112);
            f = {1'b1, pexp[c], w[c], 1'b0};
            for (int i = 0; i < 110; i++) begin
                n_checks++;
                if (line_tr[i] !== f[i/10]) begin n_fail++; $display("FAIL parity%0d_line[%0d]: got %b want %b", c, i, line_tr[i], f[i/10]); end
            end
            n_checks++; if (done_tr[109] !== 1'b0) begin n_fail++; $display("FAIL parity%0d_done_early: got %b want 0", c, done_tr[109]); end
            n_checks++; if (done_tr[110] !== 1'b1) begin n_fail++; $display("FAIL parity%0d_done_at_110: got %b want 1", c, done_tr[110]); end
            n_checks++; if (st_tr[110] !== 1'b0) begin n_fail++; $display("FAIL parity%0d_busy_falls: got %b want 0", c, st_tr[110]); end
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask
`else
    task automatic test_parity_ignored();
        parity_en = 1'b1; parity_odd = 1'b1;
        data_in = 8'h07; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        record(0, 102);
        for (int i = 90; i < 100; i++) begin
            n_checks++;
            if (line_tr[i] !== 1'b1) begin n_fail++; $display("FAIL noparity_stop[%0d]: got %b want 1", i, line_tr[i]); end
        end
        n_checks++; if (done_tr[100] !== 1'b1) begin n_fail++; $display("FAIL noparity_done_at_100: got %b want 1", done_tr[100]); end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask
`endif

    task automatic test_stop2_w5();
        logic [7:0] f;
        f = {2'b11, 5'h1F, 1'b0};
        stop2_5 = 1'b1; d5 = 5'h1F; wr5 = 1'b1;
        tick();
        wr5 = 1'b0;
        tick();
        record(0, 82);
        for (int i = 0; i < 80; i++) begin
            n_checks++;
            if (line5_tr[i] !== f[i/10]) begin n_fail++; $display("FAIL stop2_line[%0d]: got %b want %b", i, line5_tr[i], f[i/10]); end
        end
        n_checks++; if (done5_tr[79] !== 1'b0) begin n_fail++; $display("FAIL stop2_done_early: got %b want 0", done5_tr[79]); end
        n_checks++; if (done5_tr[80] !== 1'b1) begin n_fail++; $display("FAIL stop2_done_at_80: got %b want 1", done5_tr[80]); end
        stop2_5 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t, r, b, ndone, gaps;
        logic [7:0] kw;
        logic exp_b, exp_d;
        ndone = 0; gaps = 0;
        for (int e = 1; e <= 1762; e++) begin
            if (e <= 17) begin data_in = 8'(e - 1); wr_en = 1'b1; end
            else if (e == 18) begin data_in = 8'h11; wr_en = 1'b1; end
            else wr_en = 1'b0;
            #1;
            if (e == 17) begin n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL burst_ovf_17: got %b want 0", overflow); end end
            if (e == 18) begin n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL burst_ovf_18: got %b want 1", overflow); end end
            if (e == 19) begin n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL burst_ovf_width: got %b want 0", overflow); end end
            tick();
            if (e == 1) begin n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL burst_level_1: got %0d want 1", fifo_level); end end
            if (e == 2) begin n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_first_pop: got %b want 1", busy); end end
            if (e == 16) begin n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL burst_full_16: got %b want 0", full); end end
            if (e == 17) begin n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL burst_full_17: got %b want 1", full); end end
            if (e == 18) begin n_checks++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL burst_level_drop: got %0d want 16", fifo_level); end end
            if (e >= 2) begin
                t = e - 2;
                exp_d = (t > 0 && t % 100 == 0 && t <= 1700);
                n_checks++;
                if (done !== exp_d) begin n_fail++; $display("FAIL burst_done t=%0d: got %b want %b", t, done, exp_d); end
                if (done === 1'b1) ndone++;
                if (t < 1700 && busy !== 1'b1) gaps++;
                r = t % 100;
                if (t < 1700 && r % 10 == 5) begin
                    b  = r / 10;
                    kw = 8'(t / 100);
                    exp_b = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : kw[b-1];
                    n_checks++;
                    if (tx !== exp_b) begin n_fail++; $display("FAIL burst_frame%0d_bit%0d: got %b want %b", t / 100, b, tx, exp_b); end
                end
                if (t == 1700) begin
                    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_end_busy: got %b want 0", busy); end
                    n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL burst_end_level: got %0d want 0", fifo_level); end
                end
            end
        end
        n_checks++; if (ndone != 17) begin n_fail++; $display("FAIL burst_done_count: got %0d want 17", ndone); end
        n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL burst_idle_gaps: got %0d want 0", gaps); end
    endtask

    task automatic test_baud_change();
        logic [9:0] f1, f2;
        f1 = {1'b1, 8'hA5, 1'b0};
        f2 = {1'b1, 8'h3C, 1'b0};
        baud_set = 3'd5;
        data_in = 8'hA5; wr_en = 1'b1;
        tick();
        data_in = 8'h3C;
        tick();
        wr_en = 1'b0;
        n_checks++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL baud_level_wr_and_pop: got %0d want 1", fifo_level); end
        record(0, 35);
        baud_set = 3'd4;
        record(35, 267);
        for (int i = 0; i < 100; i++) begin
            n_checks++;
            if (line_tr[i] !== f1[i/10]) begin n_fail++; $display("FAIL baud_f1_line[%0d]: got %b want %b", i, line_tr[i], f1[i/10]); end
        end
        for (int i = 100; i < 300; i++) begin
            n_checks++;
            if (line_tr[i] !== f2[(i-100)/20]) begin n_fail++; $display("FAIL baud_f2_line[%0d]: got %b want %b", i, line_tr[i], f2[(i-100)/20]); end
        end
        n_checks++; if (done_tr[100] !== 1'b1) begin n_fail++; $display("FAIL baud_done_f1: got %b want 1", done_tr[100]); end
        n_checks++; if (st_tr[100] !== 1'b1) begin n_fail++; $display("FAIL baud_busy_b2b: got %b want 1", st_tr[100]); end
        n_checks++; if (done_tr[299] !== 1'b0) begin n_fail++; $display("FAIL baud_done_f2_early: got %b want 0", done_tr[299]); end
        n_checks++; if (done_tr[300] !== 1'b1) begin n_fail++; $display("FAIL baud_done_f2: got %b want 1", done_tr[300]); end
        n_checks++; if (st_tr[300] !== 1'b0) begin n_fail++; $display("FAIL baud_busy_end: got %b want 0", st_tr[300]); end
        baud_set = 3'd5;
    endtask

    task automatic test_reset_midframe();
        int bad;
        logic [7:0] w [4];
        w = '{8'h00, 8'h11, 8'h22, 8'h33};
        for (int e = 0; e < 4; e++) begin
            data_in = w[e]; wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        n_checks++; if (fifo_level !== 5'd3) begin n_fail++; $display("FAIL rstmid_queued: got %0d want 3", fifo_level); end
        repeat (33) tick();
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_line_low: got %b want 0", tx); end
        rst = 1'b1;
        tick();
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        n_checks++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 5'd0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
    endtask

    initial begin
        #1;
        test_reset();
        test_8n1();
`ifdef UART_TX_PARITY_EN
        test_parity();
`else
        test_parity_ignored();
`endif
        test_stop2_w5();
        test_back_to_back();
        test_baud_change();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
